vdu_sequencer: RTL and testbench

VDU_SEQUENCER -- requirements
Module: vdu_sequencer

---
 rtl/vdu_sequencer_if.sv | 29 ++
 rtl/vdu_sequencer.sv | 105 ++++++++++
 tb/tb_vdu_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vdu_sequencer_if.sv
// Bus bundle between the video sequencer and its surroundings: dot enable,
// video RAM port, character generator port, CPU access port and video outputs.
interface vdu_sequencer_if;
  logic       dot_ce;
  logic [9:0] vram_addr;
  logic [7:0] vram_data;
  logic [6:0] cg_code;
  logic [3:0] cg_rs;
  logic [6:0] cg_data;
  logic       cpu_req;
  logic [9:0] cpu_addr;
  logic       cpu_gnt;
  logic       pix;
  logic       hsync;
  logic       vsync;
  logic       blank;

  // Sequencer side
  modport master (
    input  dot_ce, vram_data, cg_data, cpu_req, cpu_addr,
    output vram_addr, cg_code, cg_rs, cpu_gnt, pix, hsync, vsync, blank
  );

  // Environment side (RAM, character generator, CPU, display)
  modport slave (
    output dot_ce, vram_data, cg_data, cpu_req, cpu_addr,
    input  vram_addr, cg_code, cg_rs, cpu_gnt, pix, hsync, vsync, blank
  );
endinterface

// File: rtl/vdu_sequencer.sv
// Text-mode video sequencer: 8-dot characters, 64 columns x 312 lines per
// frame, 48x16 visible text cells of 16 scan lines each. Fetches the
// character code from video RAM, looks up the dot row in the character
// generator and serialises it, with one character time of pipeline latency.
// The CPU shares the video RAM in the dots the fetch does not use.
module vdu_sequencer (
  input  logic clk,
  input  logic rst,
  vdu_sequencer_if.master bus
);

  logic [2:0] dot_q, dot_d;
  logic [5:0] col_q, col_d;
  logic [8:0] line_q, line_d;
  logic [6:0] cg_code_q, cg_code_d;
  logic [7:0] shift_q, shift_d;
  logic       blank_q, blank_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  logic active;
  logic slot_ok;
  logic cpu_gnt;
  logic unused_vram_bit7;

  // Visible area is col < 48 and line < 256; the fetch dots 0..2 belong to
  // the video side there, everywhere else the CPU may use any dot.
  always_comb begin
    active  = (col_q[5:4] != 2'b11) && !line_q[8];
    slot_ok = !active || (dot_q == 3'd4) || (dot_q == 3'd5);
    cpu_gnt = bus.cpu_req && bus.dot_ce && slot_ok && !rst;
  end

  // Top bit of the RAM word carries no character information.
  assign unused_vram_bit7 = bus.vram_data[7];

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.vram_addr = cpu_gnt ? bus.cpu_addr : {line_q[7:4], col_q};
  assign bus.cg_code   = cg_code_q;
  assign bus.cg_rs     = line_q[3:0];
  assign bus.pix       = shift_q[7];
  assign bus.blank     = blank_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;

  // Next-state: raster counters, fetch pipeline and delayed sync/blank.
  always_comb begin
    dot_d     = dot_q;
    col_d     = col_q;
    line_d    = line_q;
    cg_code_d = cg_code_q;
    shift_d   = shift_q;
    blank_d   = blank_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    if (bus.dot_ce) begin
      dot_d = dot_q + 3'd1;
      if (dot_q == 3'd7) begin
        col_d = col_q + 6'd1;
        if (col_q == 6'd63) begin
          line_d = (line_q == 9'd311) ? 9'd0 : line_q + 9'd1;
        end
      end
      // A CPU grant on the capture dot (only possible while blanked) must
      // not leak CPU data into the character code.
      if ((dot_q == 3'd2) && !cpu_gnt) begin
        cg_code_d = bus.vram_data[6:0];
      end
      if (dot_q == 3'd7) begin
        // Load the dot row for the character just fetched; sync and blank
        // are sampled at the same instant so they line up with its pixels.
        shift_d = active ? {bus.cg_data, 1'b0} : 8'd0;
        blank_d = !active;
        hsync_d = (col_q >= 6'd52) && (col_q <= 6'd55);
        vsync_d = (line_q >= 9'd272) && (line_q <= 9'd275);
      end else begin
        shift_d = {shift_q[6:0], 1'b0};
      end
    end
  end

  // State registers; reset blanks the display and abandons any fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dot_q     <= 3'd0;
      col_q     <= 6'd0;
      line_q    <= 9'd0;
      cg_code_q <= 7'd0;
      shift_q   <= 8'd0;
      blank_q   <= 1'b1;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      dot_q     <= dot_d;
      col_q     <= col_d;
      line_q    <= line_d;
      cg_code_q <= cg_code_d;
      shift_q   <= shift_d;
      blank_q   <= blank_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

endmodule

// File: tb/tb_vdu_sequencer.sv
// Directed bench for vdu_sequencer: reset, pixel pipeline, arbitration,
// blanking/sync timing, frame wrap, stall and mid-line reset.
module tb_vdu_sequencer;

  logic clk;
  logic rst;
  int   k;
  int   n_vec;
  int   n_err;
  logic [7:0] pat;
  logic [7:0] vram [0:1023];

  vdu_sequencer_if vif ();

  vdu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  // RAM and character generator models (combinational reads)
  assign vif.vram_data = vram[vif.vram_addr];
  assign vif.cg_data   = ((vif.cg_code == 7'h41) && (vif.cg_rs == 4'd0)) ? 7'b1010101 : 7'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("vec %0d %s: 0x%0h ok", n_vec, tag, obs);
    end
  endtask

  // One dot_ce clock; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    k = k + 1;
  endtask

  task automatic advance_to(input int target);
    while (k < target) step();
  endtask

  initial begin
    rst = 1'b0;
    vif.dot_ce = 1'b1;
    vif.cpu_req = 1'b0;
    vif.cpu_addr = 10'd0;
    k = 0;
    n_vec = 0;
    n_err = 0;
    pat = 8'b1010_1010;
    for (int i = 0; i < 1024; i++) vram[i] = 8'h00;
    vram[0]  = 8'h41;
    vram[2]  = 8'h23;
    vram[54] = 8'h5A;

    // Reset values, before any clock edge
    #1;
    rst = 1'b1;
    vif.cpu_req = 1'b1;
    vif.cpu_addr = 10'h3FF;
    #1;
    check_val("rst_pix", vif.pix, 0);
    check_val("rst_blank", vif.blank, 1);
    check_val("rst_hsync", vif.hsync, 0);
    check_val("rst_vsync", vif.vsync, 0);
    check_val("rst_cg_code", vif.cg_code, 0);
    check_val("rst_vram_addr", vif.vram_addr, 0);
    check_val("rst_cpu_gnt", vif.cpu_gnt, 0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    vif.cpu_req = 1'b0;
    vif.cpu_addr = 10'd0;
    k = 0;

    // First dot_ce after release
    step();
    check_val("first_dot", dut.dot_q, 1);
    check_val("first_col", dut.col_q, 0);
    check_val("first_line", dut.line_q, 0);
    check_val("first_blank", vif.blank, 1);

    advance_to(3);
    check_val("cg_code_col0", vif.cg_code, 8'h41);

    // Column 0 pixels during character time 1, with a stall in the middle
    advance_to(7);
    for (int i = 0; i < 8; i++) begin
      step();
      check_val($sformatf("pix_col1_%0d", i), vif.pix, pat[7-i]);
      if (i == 0) check_val("blank_col1", vif.blank, 0);
      if (i == 4) begin
        vif.dot_ce = 1'b0;
        vif.cpu_req = 1'b1;
        #1;
        check_val("stall_gnt0", vif.cpu_gnt, 0);
        for (int c = 0; c < 100; c++) begin
          @(posedge clk);
          #1;
          check_val("stall_gnt", vif.cpu_gnt, 0);
        end
        check_val("stall_dot", dut.dot_q, 4);
        check_val("stall_col", dut.col_q, 1);
        check_val("stall_pix", vif.pix, 1);
        vif.cpu_req = 1'b0;
        vif.dot_ce = 1'b1;
      end
    end

    // CPU request in active region waits for dot 4
    advance_to(16);
    vif.cpu_req = 1'b1;
    vif.cpu_addr = 10'h155;
    #1;
    check_val("arb_gnt_dot0", vif.cpu_gnt, 0);
    advance_to(19);
    check_val("arb_gnt_dot3", vif.cpu_gnt, 0);
    step();
    check_val("arb_gnt_dot4", vif.cpu_gnt, 1);
    check_val("arb_addr_dot4", vif.vram_addr, 10'h155);
    check_val("arb_cg_code", vif.cg_code, 8'h23);
    vif.cpu_req = 1'b0;
    vif.cpu_addr = 10'd0;
    step();
    check_val("arb_gnt_dot5", vif.cpu_gnt, 0);
    check_val("arb_addr_dot5", vif.vram_addr, 10'd2);
    check_val("arb_cg_code_after", vif.cg_code, 8'h23);

    // Horizontal blanking starts at character time 49
    advance_to(391);
    check_val("blank_col48_pre", vif.blank, 0);
    step();
    check_val("blank_col48", vif.blank, 1);

    // CPU in blanking is granted at once, even on dot 3
    advance_to(403);
    vif.cpu_req = 1'b1;
    vif.cpu_addr = 10'h2AA;
    #1;
    check_val("blank_gnt", vif.cpu_gnt, 1);
    check_val("blank_gnt_addr", vif.vram_addr, 10'h2AA);
    vif.cpu_req = 1'b0;
    vif.cpu_addr = 10'd0;
    vram[0] = 8'hC1;

    // hsync high for character times 53..56
    advance_to(423);
    check_val("hsync_pre", vif.hsync, 0);
    step();
    check_val("hsync_rise", vif.hsync, 1);
    advance_to(455);
    check_val("hsync_last", vif.hsync, 1);
    step();
    check_val("hsync_fall", vif.hsync, 0);

    // Bit 7 of RAM data dropped
    advance_to(511);
    check_val("cg_code_col63", vif.cg_code, 0);
    advance_to(515);
    check_val("cg_code_bit7", vif.cg_code, 8'h41);

    // Jump to end of line 271 to observe vsync onset
    advance_to(519);
    check_val("pre_vs_dot", dut.dot_q, 7);
    force dut.line_q = 9'd271;
    force dut.col_q = 6'd63;
    #1;
    release dut.line_q;
    release dut.col_q;
    step();
    check_val("vs_line", dut.line_q, 272);
    check_val("vs_col", dut.col_q, 0);
    repeat (7) step();
    check_val("vsync_pre", vif.vsync, 0);
    step();
    check_val("vsync_rise", vif.vsync, 1);
    check_val("vsync_blank", vif.blank, 1);

    // Frame wrap from line 311, col 63, dot 7
    repeat (7) step();
    check_val("pre_wrap_dot", dut.dot_q, 7);
    force dut.line_q = 9'd311;
    force dut.col_q = 6'd63;
    #1;
    release dut.line_q;
    release dut.col_q;
    step();
    check_val("wrap_dot", dut.dot_q, 0);
    check_val("wrap_col", dut.col_q, 0);
    check_val("wrap_line", dut.line_q, 0);
    check_val("wrap_addr", vif.vram_addr, 0);

    // Mid-line reset while hsync is active
    k = 0;
    advance_to(440);
    check_val("mid_hsync", vif.hsync, 1);
    check_val("mid_cg_code", vif.cg_code, 8'h5A);
    check_val("mid_addr", vif.vram_addr, 10'd55);
    vif.cpu_req = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_pix", vif.pix, 0);
    check_val("arst_blank", vif.blank, 1);
    check_val("arst_hsync", vif.hsync, 0);
    check_val("arst_vsync", vif.vsync, 0);
    check_val("arst_cg_code", vif.cg_code, 0);
    check_val("arst_addr", vif.vram_addr, 0);
    check_val("arst_gnt", vif.cpu_gnt, 0);
    check_val("arst_dot", dut.dot_q, 0);
    #1;
    rst = 1'b0;
    vif.cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check_val("rel_dot", dut.dot_q, 1);
    check_val("rel_col", dut.col_q, 0);
    check_val("rel_line", dut.line_q, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
